dcache_sram_nway: RTL and testbench



---
 rtl/dcache_sram_nway_pkg.sv | 24 ++
 rtl/dcache_sram_nway_lru.sv | 60 ++++++
 rtl/dcache_sram_nway.sv | 183 ++++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_sram_nway_pkg.sv
// Shared definitions for the N-way dcache array: default geometry, tag-entry bit
// positions and flush-walker state encodings.
package dcache_sram_nway_pkg;

  localparam int DEF_SETS   = 16;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_TAG_W  = 23;
  localparam int DEF_LINE_W = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Tag entry layout is {valid, dirty, tag}.
  function automatic int valid_pos(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int dirty_pos(input int tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/dcache_sram_nway_lru.sv
// Per-set true-LRU ages for the dcache array; update one cycle after a touch.
// Victim is combinational: lowest invalid way, else the oldest way.
module dcache_lru
  import dcache_sram_nway_pkg::*;
#(
  parameter  int SETS  = DEF_SETS,
  parameter  int WAYS  = DEF_WAYS,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] set_i,
  input  logic [WAY_W-1:0] way_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic             inv_found;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
        end
      end
    end
  end

  // Ages stay a permutation, so the oldest way is the one holding WAYS-1.
  always_comb begin
    victim_o  = '0;
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_i[w]) begin
        victim_o  = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
          victim_o = WAY_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache line storage with combinational lookup, LRU refill
// and a flush walker that streams dirty lines out over a valid/ready write-back port.
module dcache_sram_nway
  import dcache_sram_nway_pkg::*;
#(
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  parameter  int TAG_W  = DEF_TAG_W,
  parameter  int LINE_W = DEF_LINE_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              fill_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              hit_o,
  output logic [WAY_W-1:0]  way_o,
  output logic [TAG_W+1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              inv_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_index_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);

  localparam int VALID_POS = valid_pos(TAG_W);
  localparam int DIRTY_POS = dirty_pos(TAG_W);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] fset_q, fset_d;
  logic [WAY_W-1:0] fway_q, fway_d;
  logic             inv_q, inv_d;
  logic             advance, clr_valid, clr_dirty;

  logic             busy, hit_raw, wr_en, touch;
  logic [WAY_W-1:0] hit_way, victim, way_sel;

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    hit_raw = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_raw && valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i)) begin
        hit_raw = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign way_sel = hit_raw ? hit_way : victim;
  assign wr_en   = enable_i & ~busy & write_i;
  assign touch   = enable_i & ~busy & (hit_raw | write_i);

  dcache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .touch_i  (touch),
    .set_i    (addr_i),
    .way_i    (way_sel),
    .valid_i  (valid_q[addr_i]),
    .victim_o (victim)
  );

  always_comb begin
    hit_o                = hit_raw & ~busy;
    way_o                = way_sel;
    tag_o                = '0;
    tag_o[TAG_W-1:0]     = tag_q[addr_i][way_sel];
    tag_o[DIRTY_POS]     = dirty_q[addr_i][way_sel];
    tag_o[VALID_POS]     = valid_q[addr_i][way_sel];
    data_o               = data_q[addr_i][way_sel];
  end

  always_comb begin
    state_d   = state_q;
    fset_d    = fset_q;
    fway_d    = fway_q;
    inv_d     = inv_q;
    advance   = 1'b0;
    clr_valid = 1'b0;
    clr_dirty = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_SCAN;
          fset_d  = '0;
          fway_d  = '0;
          inv_d   = inv_i;
        end
      end
      ST_SCAN: begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          state_d = ST_EMIT;
        end else begin
          clr_valid = inv_q;
          advance   = 1'b1;
        end
      end
      ST_EMIT: begin
        if (wb_ready_i) begin
          clr_dirty = 1'b1;
          clr_valid = inv_q;
          advance   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      state_d = ST_SCAN;
      if (fway_q == WAY_W'(WAYS - 1)) begin
        fway_d = '0;
        if (fset_q == IDX_W'(SETS - 1)) begin
          state_d = ST_DONE;
        end else begin
          fset_d = fset_q + 1'b1;
        end
      end else begin
        fway_d = fway_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      fset_q  <= '0;
      fway_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fset_q  <= fset_d;
      fway_q  <= fway_d;
      inv_q   <= inv_d;
    end
  end

  // CPU writes and walker clears never coincide: accesses are gated while busy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      if (wr_en) begin
        tag_q[addr_i][way_sel]   <= tag_i;
        data_q[addr_i][way_sel]  <= data_i;
        valid_q[addr_i][way_sel] <= 1'b1;
        dirty_q[addr_i][way_sel] <= ~fill_i;
      end
      if (clr_valid) valid_q[fset_q][fway_q] <= 1'b0;
      if (clr_dirty) dirty_q[fset_q][fway_q] <= 1'b0;
    end
  end

  assign flush_busy_o = busy;
  assign flush_done_o = (state_q == ST_DONE);
  assign wb_valid_o   = (state_q == ST_EMIT);
  assign wb_index_o   = wb_valid_o ? fset_q : '0;
  assign wb_tag_o     = wb_valid_o ? tag_q[fset_q][fway_q] : '0;
  assign wb_data_o    = wb_valid_o ? data_q[fset_q][fway_q] : '0;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway (16 sets, 4 ways): lookup/LRU vectors,
// write-back flush with a scoreboard, invalidating flush, and reset during EMIT.
module tb_dcache_sram_nway;

  logic         clk = 1'b0;
  logic         rst, en, wr, fill, flush, inv, wb_ready;
  logic [3:0]   addr;
  logic [22:0]  tag;
  logic [255:0] din;
  logic         hit, busy, done, wbv;
  logic [1:0]   way;
  logic [24:0]  tago;
  logic [255:0] dout, wbd;
  logic [3:0]   wbi;
  logic [22:0]  wbt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         en, wr, fill;
    logic [3:0]   set;
    logic [22:0]  tag;
    logic [255:0] data;
    logic         exp_hit;
    logic [1:0]   exp_way;
    logic [24:0]  exp_tag;
    logic [255:0] exp_data;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [22:0]  tag;
    logic [255:0] data;
  } wb_t;

  vec_t vt[$];
  wb_t  sb_q[$];

  dcache_sram_nway #(.SETS(16), .WAYS(4), .TAG_W(23), .LINE_W(256)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .fill_i(fill),
    .addr_i(addr), .tag_i(tag), .data_i(din),
    .hit_o(hit), .way_o(way), .tag_o(tago), .data_o(dout),
    .flush_i(flush), .inv_i(inv), .flush_busy_o(busy), .flush_done_o(done),
    .wb_valid_o(wbv), .wb_ready_i(wb_ready), .wb_index_o(wbi),
    .wb_tag_o(wbt), .wb_data_o(wbd)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] dat(input logic [22:0] t, input logic [7:0] salt);
    return {8{1'b0, salt, t}};
  endfunction

  function automatic vec_t mk(input logic e, input logic w, input logic f,
                              input logic [3:0] s, input logic [22:0] t,
                              input logic [255:0] d, input logic eh,
                              input logic [1:0] ew, input logic [24:0] et,
                              input logic [255:0] ed);
    vec_t v;
    v.en = e; v.wr = w; v.fill = f; v.set = s; v.tag = t; v.data = d;
    v.exp_hit = eh; v.exp_way = ew; v.exp_tag = et; v.exp_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] s, input logic [22:0] t, input logic f,
                          input logic [255:0] d);
    en = 1'b1; wr = 1'b1; fill = f; addr = s; tag = t; din = d;
    tick();
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic chk_lk(input string name, input logic [3:0] s, input logic [22:0] t,
                        input logic eh, input logic [1:0] ew, input logic [1:0] evd);
    en = 1'b0; addr = s; tag = t;
    #1;
    chk({name, "_hit"}, hit, eh);
    chk({name, "_way"}, way, ew);
    chk({name, "_vd"}, tago[24:23], evd);
  endtask

  // Drives one flush and services the write-back port: each offered line is held
  // with ready low for three cycles, then accepted and retired from the scoreboard.
  task automatic run_flush(input logic inv_v, input int exp_cycles, input bit poke);
    int busy_cnt, done_cnt, hold;
    bit fin;
    busy_cnt = 0; done_cnt = 0; hold = 0; fin = 0;
    flush = 1'b1; inv = inv_v;
    tick();
    flush = 1'b0; inv = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      wb_ready = 1'b0; en = 1'b0; wr = 1'b0;
      if (!busy) begin
        fin = 1'b1;
      end else begin
        busy_cnt++;
        if (done) done_cnt++;
        if (wbv) begin
          if (sb_q.size() == 0) begin
            chk("wb_unexpected", 1, 0);
          end else begin
            chk("wb_index", wbi, sb_q[0].idx);
            chk("wb_tag", wbt, sb_q[0].tag);
            chk("wb_data", wbd, sb_q[0].data);
            if (hold == 3) begin
              wb_ready = 1'b1;
              hold = 0;
              void'(sb_q.pop_front());
            end else begin
              hold++;
            end
          end
        end
        if (poke && busy_cnt == 10) begin
          en = 1'b1; wr = 1'b1; fill = 1'b0; addr = 4'd0; tag = 23'h55; din = '1;
        end
        if (poke && busy_cnt == 11) begin
          en = 1'b1; wr = 1'b0; addr = 4'd15; tag = 23'h1F0;
          #1;
          chk("hit_during_flush", hit, 0);
        end
        tick();
      end
    end
    en = 1'b0; wr = 1'b0; wb_ready = 1'b0;
    chk("flush_finished", fin, 1);
    chk("flush_busy_cycles", busy_cnt, exp_cycles);
    chk("flush_done_pulses", done_cnt, 1);
    chk("wb_remaining", sb_q.size(), 0);
  endtask

  initial begin
    int ok;
    rst = 1'b0; en = 1'b0; wr = 1'b0; fill = 1'b0; flush = 1'b0; inv = 1'b0;
    wb_ready = 1'b0; addr = '0; tag = '0; din = '0;
    do_reset();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wbv", wbv, 0);
    chk("rst_wbi", wbi, 0);
    chk("rst_wbt", wbt, 0);
    chk("rst_wbd", wbd, 0);

    // Set 3: basic fill and hit.
    vt.push_back(mk(0, 0, 0, 3, 23'h12, '0, 0, 0, '0, '0));
    vt.push_back(mk(1, 1, 1, 3, 23'h12, dat(23'h12, 1), 0, 0, '0, '0));
    vt.push_back(mk(0, 0, 0, 3, 23'h12, '0, 1, 0, {2'b10, 23'h12}, dat(23'h12, 1)));
    // Set 5: fill A..D, touch A, fill E replaces B (oldest).
    vt.push_back(mk(1, 1, 1, 5, 23'hA, dat(23'hA, 2), 0, 0, '0, '0));
    vt.push_back(mk(1, 1, 1, 5, 23'hB, dat(23'hB, 2), 0, 1, '0, '0));
    vt.push_back(mk(1, 1, 1, 5, 23'hC, dat(23'hC, 2), 0, 2, '0, '0));
    vt.push_back(mk(1, 1, 1, 5, 23'hD, dat(23'hD, 2), 0, 3, '0, '0));
    vt.push_back(mk(1, 0, 0, 5, 23'hA, '0, 1, 0, {2'b10, 23'hA}, dat(23'hA, 2)));
    vt.push_back(mk(1, 1, 1, 5, 23'hE, dat(23'hE, 2), 0, 1, {2'b10, 23'hB}, dat(23'hB, 2)));
    vt.push_back(mk(0, 0, 0, 5, 23'hB, '0, 0, 2, {2'b10, 23'hC}, dat(23'hC, 2)));
    vt.push_back(mk(0, 0, 0, 5, 23'hA, '0, 1, 0, {2'b10, 23'hA}, dat(23'hA, 2)));
    vt.push_back(mk(0, 0, 0, 5, 23'hC, '0, 1, 2, {2'b10, 23'hC}, dat(23'hC, 2)));
    vt.push_back(mk(0, 0, 0, 5, 23'hD, '0, 1, 3, {2'b10, 23'hD}, dat(23'hD, 2)));
    vt.push_back(mk(0, 0, 0, 5, 23'hE, '0, 1, 1, {2'b10, 23'hE}, dat(23'hE, 2)));
    // Set 7: CPU write over a clean hit marks it dirty, neighbour untouched.
    vt.push_back(mk(1, 1, 1, 7, 23'h7, dat(23'h7, 3), 0, 0, '0, '0));
    vt.push_back(mk(1, 1, 1, 7, 23'h8, dat(23'h8, 3), 0, 1, '0, '0));
    vt.push_back(mk(1, 1, 0, 7, 23'h7, dat(23'h7, 4), 1, 0, {2'b10, 23'h7}, dat(23'h7, 3)));
    vt.push_back(mk(0, 0, 0, 7, 23'h7, '0, 1, 0, {2'b11, 23'h7}, dat(23'h7, 4)));
    vt.push_back(mk(0, 0, 0, 7, 23'h8, '0, 1, 1, {2'b10, 23'h8}, dat(23'h8, 3)));

    for (int i = 0; i < vt.size(); i++) begin
      en = vt[i].en; wr = vt[i].wr; fill = vt[i].fill;
      addr = vt[i].set; tag = vt[i].tag; din = vt[i].data;
      #1;
      chk($sformatf("vec%0d_hit", i), hit, vt[i].exp_hit);
      chk($sformatf("vec%0d_way", i), way, vt[i].exp_way);
      chk($sformatf("vec%0d_tag", i), tago, vt[i].exp_tag);
      chk($sformatf("vec%0d_data", i), dout, vt[i].exp_data);
      tick();
    end
    en = 1'b0; wr = 1'b0;

    // Write-back flush: two dirty lines, one clean line that must stay valid.
    do_reset();
    do_write(4'd0, 23'h100, 1'b1, dat(23'h100, 5));
    do_write(4'd0, 23'h101, 1'b0, dat(23'h101, 5));
    do_write(4'd15, 23'h1F0, 1'b0, dat(23'h1F0, 5));
    sb_q.push_back('{4'd0, 23'h101, dat(23'h101, 5)});
    sb_q.push_back('{4'd15, 23'h1F0, dat(23'h1F0, 5)});
    run_flush(1'b0, 16 * 4 + 2 * 4 + 1, 1'b0);
    chk_lk("after_wb_s0w1", 4'd0, 23'h101, 1, 1, 2'b10);
    chk_lk("after_wb_s15w0", 4'd15, 23'h1F0, 1, 0, 2'b10);
    chk_lk("after_wb_s0w0", 4'd0, 23'h100, 1, 0, 2'b10);

    // Invalidating flush with accesses issued while the walker runs.
    run_flush(1'b1, 16 * 4 + 1, 1'b1);
    chk_lk("after_inv_s0_poke", 4'd0, 23'h55, 0, 0, 2'b00);
    chk_lk("after_inv_s15", 4'd15, 23'h1F0, 0, 0, 2'b00);
    ok = 0;
    for (int s = 0; s < 16; s++) begin
      addr = 4'(s); tag = 23'h0;
      #1;
      if (!hit && way == 2'd0 && !tago[24]) ok++;
    end
    chk("inv_all_sets_empty", ok, 16);

    // Reset while a write-back is being offered.
    do_reset();
    do_write(4'd2, 23'h33, 1'b0, dat(23'h33, 6));
    wb_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 100 && !wbv; c++) tick();
    chk("emit_reached", wbv, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_emit_wbv", wbv, 0);
    chk("rst_emit_busy", busy, 0);
    chk("rst_emit_wbi", wbi, 0);
    chk_lk("rst_emit_line", 4'd2, 23'h33, 0, 0, 2'b00);
    tick();
    chk("rst_emit_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
